// File: rtl/bus_monitor_pkg.sv
// Shared types and constants for the bus protocol monitor.
//   state_t   : monitor FSM state (IDLE / ACTIVE)
//   txn_t     : attributes of the transaction in flight, latched on begin
//   V_*       : violation codes. A lower code wins when several fire together.
package bus_monitor_pkg;

  localparam int VIOL_W = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic       rnw;
    logic [7:0] burst;
  } txn_t;

  localparam logic [VIOL_W-1:0] V_NONE       = 3'd0;
  localparam logic [VIOL_W-1:0] V_NESTED     = 3'd1;
  localparam logic [VIOL_W-1:0] V_STRAY_DATA = 3'd2;
  localparam logic [VIOL_W-1:0] V_STRAY_END  = 3'd3;
  localparam logic [VIOL_W-1:0] V_BEAT_COUNT = 3'd4;
  localparam logic [VIOL_W-1:0] V_TIMEOUT    = 3'd5;
  localparam logic [VIOL_W-1:0] V_MISALIGNED = 3'd6;

endpackage

// File: rtl/bus_protocol_monitor.sv
// Passive system-bus monitor. It tracks each transaction from begin to end and
// checks beat counts, stray handshakes and hangs. It keeps statistics and never
// drives the bus.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   begin/end_transaction_i   bus strobes
//   data_valid_i, busy_i      beat handshake (a beat = valid && !busy)
//   error_i                   bus error, terminates the transaction
//   read_n_write_i,
//   burst_size_i,
//   byte_enables_i            transaction attributes, valid with begin
//   addr_data_i               address on begin, data on beats
//   active_o                  transaction in progress (registered)
//   violation_o               one-cycle pulse, cycle after the offending sample
//   violation_code_o          code of that violation, 0 otherwise
//   first_code_o              sticky code of the first violation since reset
//   *_count_o                 wrapping statistics counters
//   last_addr_o               address captured at the last begin
module bus_protocol_monitor
  import bus_monitor_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              begin_transaction_i,
  input  logic              end_transaction_i,
  input  logic              data_valid_i,
  input  logic              busy_i,
  input  logic              error_i,
  input  logic              read_n_write_i,
  input  logic [7:0]        burst_size_i,
  input  logic [3:0]        byte_enables_i,
  input  logic [31:0]       addr_data_i,
  output logic              active_o,
  output logic              violation_o,
  output logic [VIOL_W-1:0] violation_code_o,
  output logic [VIOL_W-1:0] first_code_o,
  output logic [CNT_W-1:0]  txn_count_o,
  output logic [CNT_W-1:0]  read_count_o,
  output logic [CNT_W-1:0]  write_count_o,
  output logic [CNT_W-1:0]  bus_error_count_o,
  output logic [31:0]       last_addr_o
);

  localparam int                TMO_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]        BEATS_SAT = 9'd256;

  state_t            state, state_d;
  txn_t              txn;
  logic [8:0]        beats, beats_d, beats_acc;
  logic [TMO_W-1:0]  tmo, tmo_d;
  logic              capture, complete, bus_err;
  logic [6:1]        flags;
  logic [VIOL_W-1:0] code_d;
  logic              beat_ok;

  // Byte enables carry no protocol rule the monitor checks.
  logic unused_byte_enables;
  assign unused_byte_enables = ^byte_enables_i;

  assign beat_ok = data_valid_i && !busy_i;
  // Beat count including a beat accepted this cycle, saturating at 256.
  assign beats_acc = (beat_ok && beats != BEATS_SAT) ? beats + 9'd1 : beats;

  always_comb begin
    state_d  = state;
    beats_d  = beats;
    tmo_d    = tmo;
    capture  = 1'b0;
    complete = 1'b0;
    bus_err  = 1'b0;
    flags    = '0;

    case (state)
      IDLE: begin
        // Stray strobes are flagged even when a begin is taken alongside them.
        if (data_valid_i)        flags[V_STRAY_DATA] = 1'b1;
        if (end_transaction_i)   flags[V_STRAY_END]  = 1'b1;
        if (begin_transaction_i) capture = 1'b1;
      end
      ACTIVE: begin
        if (error_i) begin
          bus_err = 1'b1;
          state_d = IDLE;
        end else if (end_transaction_i) begin
          complete = 1'b1;
          if (beats_acc != ({1'b0, txn.burst} + 9'd1)) flags[V_BEAT_COUNT] = 1'b1;
          // Back-to-back: the old transaction closes, the new one opens.
          if (begin_transaction_i) capture = 1'b1;
          else                     state_d = IDLE;
        end else if (begin_transaction_i) begin
          flags[V_NESTED] = 1'b1;
          capture         = 1'b1;
        end else if (!data_valid_i && tmo == TMO_MAX) begin
          flags[V_TIMEOUT] = 1'b1;
          state_d          = IDLE;
        end else begin
          beats_d = beats_acc;
          tmo_d   = data_valid_i ? '0 : tmo + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      beats_d = '0;
      tmo_d   = '0;
    end

    if (capture) begin
      state_d = ACTIVE;
      beats_d = '0;
      tmo_d   = '0;
      if (addr_data_i[1:0] != 2'b00) flags[V_MISALIGNED] = 1'b1;
    end

    // Lowest code wins.
    if      (flags[1]) code_d = V_NESTED;
    else if (flags[2]) code_d = V_STRAY_DATA;
    else if (flags[3]) code_d = V_STRAY_END;
    else if (flags[4]) code_d = V_BEAT_COUNT;
    else if (flags[5]) code_d = V_TIMEOUT;
    else if (flags[6]) code_d = V_MISALIGNED;
    else               code_d = V_NONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= IDLE;
      txn               <= '0;
      beats             <= '0;
      tmo               <= '0;
      active_o          <= 1'b0;
      violation_o       <= 1'b0;
      violation_code_o  <= V_NONE;
      first_code_o      <= V_NONE;
      txn_count_o       <= '0;
      read_count_o      <= '0;
      write_count_o     <= '0;
      bus_error_count_o <= '0;
      last_addr_o       <= '0;
    end else begin
      state    <= state_d;
      beats    <= beats_d;
      tmo      <= tmo_d;
      active_o <= (state_d == ACTIVE);

      if (capture) begin
        txn         <= '{rnw: read_n_write_i, burst: burst_size_i};
        last_addr_o <= addr_data_i;
      end

      // Uses the attributes of the closing transaction; capture updates txn
      // only after this edge.
      if (complete) begin
        txn_count_o <= txn_count_o + CNT_W'(1);
        if (txn.rnw) read_count_o  <= read_count_o + CNT_W'(1);
        else         write_count_o <= write_count_o + CNT_W'(1);
      end

      if (bus_err) bus_error_count_o <= bus_error_count_o + CNT_W'(1);

      violation_o      <= (code_d != V_NONE);
      violation_code_o <= code_d;
      if (first_code_o == V_NONE) first_code_o <= code_d;
    end
  end

endmodule

// File: tb/tb_bus_protocol_monitor.sv
// Directed bench for bus_protocol_monitor (TIMEOUT_CYCLES=1024, CNT_W=32).
// Inputs change 1 ns after each rising edge; outputs are checked at that point.
module tb_bus_protocol_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bgn = 1'b0, en = 1'b0, dv = 1'b0, busy = 1'b0, err = 1'b0, rnw = 1'b0;
  logic [7:0]  bsz = '0;
  logic [3:0]  be  = 4'hF;
  logic [31:0] ad  = '0;

  logic        active, viol;
  logic [2:0]  vcode, fcode;
  logic [31:0] txn_cnt, rd_cnt, wr_cnt, berr_cnt, last_addr;

  int vectors    = 0;
  int miscompares = 0;
  logic viol_seen = 1'b0;

  bus_protocol_monitor #(.TIMEOUT_CYCLES(1024), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .begin_transaction_i(bgn), .end_transaction_i(en),
    .data_valid_i(dv), .busy_i(busy), .error_i(err),
    .read_n_write_i(rnw), .burst_size_i(bsz), .byte_enables_i(be),
    .addr_data_i(ad),
    .active_o(active), .violation_o(viol), .violation_code_o(vcode),
    .first_code_o(fcode), .txn_count_o(txn_cnt), .read_count_o(rd_cnt),
    .write_count_o(wr_cnt), .bus_error_count_o(berr_cnt), .last_addr_o(last_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of bus inputs, then step past the edge.
  task automatic cyc(input logic b, input logic e, input logic d, input logic bz,
                     input logic er, input logic r, input logic [7:0] s, input logic [31:0] a);
    bgn = b; en = e; dv = d; busy = bz; err = er; rnw = r; bsz = s; ad = a;
    @(posedge clk); #1;
    if (viol) viol_seen = 1'b1;
  endtask

  task automatic idle();            cyc(0,0,0,0,0,0,8'd0,32'h0); endtask
  task automatic start(input logic r, input logic [7:0] s, input logic [31:0] a);
                                    cyc(1,0,0,0,0,r,s,a); endtask
  task automatic beat(input logic bz, input logic [31:0] d);
                                    cyc(0,0,1,bz,0,0,8'd0,d); endtask
  task automatic finish_txn();      cyc(0,1,0,0,0,0,8'd0,32'h0); endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_active"}, {31'd0, active}, 32'd0);
    chk({tag, "_viol"},   {31'd0, viol}, 32'd0);
    chk({tag, "_vcode"},  {29'd0, vcode}, 32'd0);
    chk({tag, "_fcode"},  {29'd0, fcode}, 32'd0);
    chk({tag, "_txn"},    txn_cnt, 32'd0);
    chk({tag, "_rd"},     rd_cnt, 32'd0);
    chk({tag, "_wr"},     wr_cnt, 32'd0);
    chk({tag, "_berr"},   berr_cnt, 32'd0);
    chk({tag, "_addr"},   last_addr, 32'd0);
  endtask

  initial begin
    logic early;
    // Reset
    rst = 1'b1;
    idle(); idle();
    chk_all_zero("reset");
    rst = 1'b0;
    idle();

    // 1: read, burst_size=3, four beats
    viol_seen = 1'b0;
    start(1'b1, 8'd3, 32'h0000_1000);
    chk("t1_active", {31'd0, active}, 32'd1);
    chk("t1_addr", last_addr, 32'h0000_1000);
    for (int i = 0; i < 4; i++) beat(1'b0, 32'hA000_0000 + i);
    finish_txn();
    chk("t1_active_end", {31'd0, active}, 32'd0);
    chk("t1_txn", txn_cnt, 32'd1);
    chk("t1_rd", rd_cnt, 32'd1);
    chk("t1_wr", wr_cnt, 32'd0);
    idle();
    chk("t1_no_viol", {31'd0, viol_seen}, 32'd0);

    // 2: write, burst_size=0, one beat plus two busy-stalled cycles
    viol_seen = 1'b0;
    start(1'b0, 8'd0, 32'h0000_2004);
    beat(1'b0, 32'h1111_1111);
    beat(1'b1, 32'h2222_2222);
    beat(1'b1, 32'h3333_3333);
    finish_txn();
    idle();
    chk("t2_no_viol", {31'd0, viol_seen}, 32'd0);
    chk("t2_txn", txn_cnt, 32'd2);
    chk("t2_wr", wr_cnt, 32'd1);

    // 3: burst_size=7 but only five beats
    start(1'b0, 8'd7, 32'h0000_3000);
    for (int i = 0; i < 5; i++) beat(1'b0, 32'hB000_0000 + i);
    finish_txn();
    chk("t3_viol", {31'd0, viol}, 32'd1);
    chk("t3_code", {29'd0, vcode}, 32'd4);
    chk("t3_first", {29'd0, fcode}, 32'd4);
    chk("t3_txn", txn_cnt, 32'd3);
    chk("t3_wr", wr_cnt, 32'd2);
    idle();
    chk("t3_pulse_viol", {31'd0, viol}, 32'd0);
    chk("t3_pulse_code", {29'd0, vcode}, 32'd0);

    // 4: hang -> timeout 1024 cycles after begin, visible one cycle later
    start(1'b1, 8'd0, 32'h0000_4000);
    early = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      idle();
      if (viol || !active) early = 1'b1;
    end
    chk("t4_no_early", {31'd0, early}, 32'd0);
    idle();
    chk("t4_viol", {31'd0, viol}, 32'd1);
    chk("t4_code", {29'd0, vcode}, 32'd5);
    chk("t4_active", {31'd0, active}, 32'd0);
    chk("t4_txn", txn_cnt, 32'd3);
    chk("t4_first", {29'd0, fcode}, 32'd4);

    // 5: misaligned begin, then nested begin
    rst = 1'b1; idle();
    chk_all_zero("rst2");
    rst = 1'b0; idle();
    start(1'b1, 8'd1, 32'h0000_0102);
    chk("t5_code6", {29'd0, vcode}, 32'd6);
    chk("t5_active", {31'd0, active}, 32'd1);
    start(1'b1, 8'd1, 32'h0000_0200);
    chk("t5_code1", {29'd0, vcode}, 32'd1);
    chk("t5_first", {29'd0, fcode}, 32'd6);
    chk("t5_addr", last_addr, 32'h0000_0200);
    beat(1'b0, 32'h5); beat(1'b0, 32'h6);
    finish_txn();
    chk("t5_end_viol", {31'd0, viol}, 32'd0);
    chk("t5_txn", txn_cnt, 32'd1);
    chk("t5_rd", rd_cnt, 32'd1);

    // 6: bus error mid-burst, then reset mid-transaction
    start(1'b0, 8'd3, 32'h0000_0300);
    beat(1'b0, 32'h7);
    cyc(0,0,0,0,1,0,8'd0,32'h0);
    chk("t6_berr", berr_cnt, 32'd1);
    chk("t6_viol", {31'd0, viol}, 32'd0);
    chk("t6_active", {31'd0, active}, 32'd0);
    chk("t6_txn", txn_cnt, 32'd1);
    start(1'b1, 8'd3, 32'h0000_0400);
    beat(1'b0, 32'h8);
    rst = 1'b1; idle();
    chk_all_zero("rst3");
    rst = 1'b0; idle();

    // 7: end+begin back-to-back, then stray strobes in IDLE
    start(1'b1, 8'd0, 32'h0000_0500);
    beat(1'b0, 32'h9);
    cyc(1,1,0,0,0,0,8'd0,32'h0000_0600);
    chk("t7_b2b_viol", {31'd0, viol}, 32'd0);
    chk("t7_b2b_txn", txn_cnt, 32'd1);
    chk("t7_b2b_rd", rd_cnt, 32'd1);
    chk("t7_b2b_active", {31'd0, active}, 32'd1);
    chk("t7_b2b_addr", last_addr, 32'h0000_0600);
    beat(1'b0, 32'hA);
    finish_txn();
    chk("t7_txn", txn_cnt, 32'd2);
    chk("t7_wr", wr_cnt, 32'd1);
    chk("t7_viol", {31'd0, viol}, 32'd0);
    beat(1'b0, 32'hB);
    chk("t7_stray_data", {29'd0, vcode}, 32'd2);
    chk("t7_first", {29'd0, fcode}, 32'd2);
    finish_txn();
    chk("t7_stray_end", {29'd0, vcode}, 32'd3);
    cyc(1,1,0,0,0,1,8'd0,32'h0000_0700);
    chk("t7_beg_end_code", {29'd0, vcode}, 32'd3);
    chk("t7_beg_end_active", {31'd0, active}, 32'd1);
    chk("t7_beg_end_addr", last_addr, 32'h0000_0700);
    chk("t7_first_sticky", {29'd0, fcode}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_protocol_monitor.md
Name: bus_protocol_monitor

Overview:
Passive observer on the single-core SoC system bus, placed next to the memory slave in the simulation harness.
- Samples the combined bus wires each cycle and tracks each transaction from begin to end.
- Checks burst beat counts, stray handshakes and hangs.
- Reports violations and keeps transaction statistics for the C++ test driver.
- Never drives the bus.

Parameters:
TIMEOUT_CYCLES, 1024, cycles in ACTIVE with no data_valid_i/end_transaction_i before timeout (>=2)
CNT_W, 32, width of all statistics counters

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
begin_transaction_i  in  1  bus begin strobe
end_transaction_i  in  1  bus end strobe (master or slave side, ORed)
data_valid_i  in  1  bus data-valid (ORed)
busy_i  in  1  bus busy (ORed)
error_i  in  1  bus error (ORed)
read_n_write_i  in  1  transaction direction, valid with begin
burst_size_i  in  8  beats minus one, valid with begin
byte_enables_i  in  4  valid with begin
addr_data_i  in  32  address on begin, data on beats
active_o  out  1  transaction in progress
violation_o  out  1  one-cycle pulse on any violation
violation_code_o  out  3  code of current violation (0 when none)
first_code_o  out  3  sticky code of first violation since reset
txn_count_o  out  CNT_W  completed transactions
read_count_o  out  CNT_W  completed reads
write_count_o  out  CNT_W  completed writes
bus_error_count_o  out  CNT_W  transactions terminated by error_i
last_addr_o  out  32  address captured at last begin

Behaviour:
- Reset: all outputs and counters are 0. State is IDLE. The beat counter and timeout counter are 0. Reset mid-transaction discards the transaction and records nothing.
- Violation codes: 1 NESTED_BEGIN, 2 STRAY_DATA, 3 STRAY_END, 4 BEAT_COUNT, 5 TIMEOUT, 6 MISALIGNED.
- Violation outputs are registered: violation_o and violation_code_o are valid the cycle after the offending sample.
- If several violations occur in one cycle, the lowest code wins.
- first_code_o loads only while it is 0.

IDLE:
- begin_transaction_i:
  - capture addr_data_i into last_addr_o, plus read_n_write_i and burst_size_i;
  - set beats=0 and tmo=0;
  - go to ACTIVE;
  - if addr_data_i[1:0]!=0, flag MISALIGNED but still enter ACTIVE.
- data_valid_i without begin: STRAY_DATA.
- end_transaction_i without begin: STRAY_END.
- A begin sampled in the same cycle as stray data or end: begin is taken; the stray event is flagged.

ACTIVE:
- Beats: data_valid_i && !busy_i increments beats. The counter saturates at 256.
- Timeout counter: tmo increments every cycle without data_valid_i or end_transaction_i, and resets when either is seen.
- Timeout: tmo==TIMEOUT_CYCLES-1 flags TIMEOUT and returns to IDLE. No txn counters update.
- Bus error: error_i increments bus_error_count_o and returns to IDLE. No violation; txn counters do not update.
- End: end_transaction_i completes the transaction.
  - beats (including a beat accepted this cycle) must equal burst_size+1; otherwise BEAT_COUNT.
  - txn_count_o and read_count_o or write_count_o increment even on BEAT_COUNT.
  - Returns to IDLE.
- Begin, no end: begin_transaction_i without end_transaction_i flags NESTED_BEGIN. The old transaction is abandoned with no count, and the new one is captured.
- Begin with end: end is processed first (counting, checks), then the new transaction starts. State stays ACTIVE.
- Priority within ACTIVE: error_i > end > timeout.

Other rules:
- active_o = (state==ACTIVE), registered.
- Counters wrap modulo 2^CNT_W.

Decomposition:
- Package bus_monitor_pkg: state enum (IDLE, ACTIVE), violation-code constants, VIOL_W=3.
- No sub-module. The counter bank is inline.

Test Plan:
- Read, burst_size=3, 4 beats, end -> txn=1, read=1, violation_o never high, last_addr_o=begin address.
- Write, burst_size=0: 1 beat plus 2 busy-stalled data_valid cycles, then end -> beats=1, no violation, write=1.
- Burst_size=7, only 5 beats, then end -> violation_code_o=4 one cycle after end, first_code_o=4, txn=1.
- Begin, then 1024 idle cycles (TIMEOUT_CYCLES=1024) -> code 5 exactly 1024 cycles after begin plus 1 registered cycle; active_o=0; txn=0.
- Begin at 0x102, then a second begin while active -> codes 6 then 1, first_code_o=6; then end with correct beats -> txn=1.
- error_i mid-burst -> bus_error_count_o=1, no violation, state IDLE. Then reset mid-transaction -> all outputs 0.
